// File: rtl/ibex_instr_bus_arbiter_if.sv
// Signal bundle between the two fetch requesters, the shared instruction
// memory port and the arbiter; slave is the arbiter side, master the environment.
interface ibex_instr_bus_arbiter_if;
  logic        a_req_i;
  logic [31:0] a_addr_i;
  logic        a_gnt_o;
  logic        a_rvalid_o;
  logic        b_req_i;
  logic [31:0] b_addr_i;
  logic        b_gnt_o;
  logic        b_rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        busy_o;
  logic        protocol_err_o;

  modport slave (
    input  a_req_i, a_addr_i, b_req_i, b_addr_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output a_gnt_o, a_rvalid_o, b_gnt_o, b_rvalid_o, rdata_o, err_o,
    output mem_req_o, mem_addr_o, busy_o, protocol_err_o
  );

  modport master (
    output a_req_i, a_addr_i, b_req_i, b_addr_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  a_gnt_o, a_rvalid_o, b_gnt_o, b_rvalid_o, rdata_o, err_o,
    input  mem_req_o, mem_addr_o, busy_o, protocol_err_o
  );
endinterface

// File: rtl/ibex_instr_bus_arbiter.sv
// Two-requester instruction-fetch arbiter: picks a winner, holds it until the
// memory grants, and routes in-order responses back through an owner FIFO.
module ibex_instr_bus_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          RoundRobin     = 1'b1
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  ibex_instr_bus_arbiter_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(MaxOutstanding + 1);
  localparam int unsigned     PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

  typedef enum logic {
    IdA = 1'b0,
    IdB = 1'b1
  } req_id_e;

  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [PtrW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [MaxOutstanding-1:0] owner_q, owner_d;
  logic                      lock_q, lock_d;
  req_id_e                   locked_id_q, locked_id_d;
  req_id_e                   rr_q, rr_d;
  logic                      prot_err_q, prot_err_d;

  req_id_e     sel;
  logic        sel_req;
  logic [31:0] sel_addr;
  logic        full, empty, push, pop, head_id;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? {PtrW{1'b0}} : p + PtrW'(1);
  endfunction

  // Winner selection: a stalled winner stays selected until the memory accepts it.
  always_comb begin
    sel = IdA;
    if (lock_q) begin
      sel = locked_id_q;
    end else if (bus.a_req_i && bus.b_req_i) begin
      sel = RoundRobin ? rr_q : IdA;
    end else if (bus.b_req_i) begin
      sel = IdB;
    end else begin
      sel = IdA;
    end
    sel_req  = (sel == IdB) ? bus.b_req_i  : bus.a_req_i;
    sel_addr = (sel == IdB) ? bus.b_addr_i : bus.a_addr_i;
  end

  assign full    = (cnt_q == CntMax);
  assign empty   = (cnt_q == {CntW{1'b0}});
  assign head_id = owner_q[rptr_q];
  assign push    = bus.mem_req_o & bus.mem_gnt_i;
  assign pop     = bus.mem_rvalid_i & ~empty;

  assign bus.mem_req_o      = sel_req & ~full;
  assign bus.mem_addr_o     = {sel_addr[31:2], 2'b00};
  assign bus.a_gnt_o        = push & (sel == IdA);
  assign bus.b_gnt_o        = push & (sel == IdB);
  assign bus.a_rvalid_o     = pop & (head_id == 1'b0);
  assign bus.b_rvalid_o     = pop & (head_id == 1'b1);
  assign bus.rdata_o        = bus.mem_rdata_i;
  assign bus.err_o          = bus.mem_err_i;
  assign bus.busy_o         = bus.mem_req_o | ~empty;
  assign bus.protocol_err_o = prot_err_q;

  // Next state for owner FIFO, lock, round-robin pointer and sticky error.
  always_comb begin
    cnt_d       = cnt_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    owner_d     = owner_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    rr_d        = rr_q;
    prot_err_d  = prot_err_q | (bus.mem_rvalid_i & empty);

    if (push) begin
      owner_d[wptr_q] = sel;
      wptr_d          = ptr_inc(wptr_q);
      rr_d            = (sel == IdA) ? IdB : IdA;
    end else begin
      wptr_d = wptr_q;
    end

    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end else begin
      rptr_d = rptr_q;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    // A dropped request while locked also lands in the final branch.
    if (push) begin
      lock_d = 1'b0;
    end else if (bus.mem_req_o) begin
      lock_d      = 1'b1;
      locked_id_d = sel;
    end else begin
      lock_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= {CntW{1'b0}};
      wptr_q      <= {PtrW{1'b0}};
      rptr_q      <= {PtrW{1'b0}};
      owner_q     <= {MaxOutstanding{1'b0}};
      lock_q      <= 1'b0;
      locked_id_q <= IdA;
      rr_q        <= IdA;
      prot_err_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      owner_q     <= owner_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      rr_q        <= rr_d;
      prot_err_q  <= prot_err_d;
    end
  end

  ibex_instr_bus_arbiter_chk u_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .a_gnt_i     (bus.a_gnt_o),
    .b_gnt_i     (bus.b_gnt_o),
    .a_req_i     (bus.a_req_i),
    .b_req_i     (bus.b_req_i),
    .lock_i      (lock_q),
    .locked_id_i (locked_id_q == IdB)
  );

endmodule

// Protocol checks: grants are exclusive and a stalled requester keeps requesting.
module ibex_instr_bus_arbiter_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic a_gnt_i,
  input logic b_gnt_i,
  input logic a_req_i,
  input logic b_req_i,
  input logic lock_i,
  input logic locked_id_i
);

  gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) !(a_gnt_i && b_gnt_i));

  locked_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_i |-> (locked_id_i ? b_req_i : a_req_i));

endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// Randomized bench for ibex_instr_bus_arbiter: a queue-based reference model
// predicts grants per cycle; a scoreboard checks routed responses.
module tb_ibex_instr_bus_arbiter;

  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  ibex_instr_bus_arbiter_if bus ();

  ibex_instr_bus_arbiter #(
    .MaxOutstanding (MAXO),
    .RoundRobin     (1'b1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t exp_q[$];

  // Reference model: ids of accepted-but-unanswered fetches (0 = A, 1 = B),
  // who was served last, and whether a stalled winner is being held.
  bit          owners[$];
  bit          last_id = 1'b1;
  bit          held = 1'b0;
  bit          held_id = 1'b0;
  bit          m_prot = 1'b0;
  bit          b_fix_en = 1'b0;
  logic [31:0] b_fix = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit ar, input bit br, input bit g, input bit rv, input bit rstn);
    bit          win, wreq, ereq, egnt;
    logic [31:0] waddr;
    resp_t       e;
    @(negedge clk);
    if (held) begin
      if (held_id) br = 1'b1;
      else         ar = 1'b1;
    end
    if (!rstn) begin
      ar = 1'b0; br = 1'b0; g = 1'b0; rv = 1'b0;
    end
    bus.a_req_i      = ar;
    bus.b_req_i      = br;
    bus.a_addr_i     = $urandom;
    bus.b_addr_i     = b_fix_en ? b_fix : $urandom;
    bus.mem_gnt_i    = g;
    bus.mem_rvalid_i = rv;
    bus.mem_rdata_i  = $urandom;
    bus.mem_err_i    = 1'($urandom_range(0, 1));
    rst_ni           = rstn;
    if (!rstn) begin
      owners.delete();
      exp_q.delete();
      held    = 1'b0;
      last_id = 1'b1;
      m_prot  = 1'b0;
    end
    if (rv && owners.size() > 0) begin
      e.id   = owners[0];
      e.data = bus.mem_rdata_i;
      e.err  = bus.mem_err_i;
      exp_q.push_back(e);
    end
    if (held)          win = held_id;
    else if (ar && br) win = ~last_id;
    else               win = br;
    wreq  = win ? br : ar;
    ereq  = wreq && (owners.size() < MAXO);
    egnt  = ereq && g;
    waddr = win ? bus.b_addr_i : bus.a_addr_i;
    waddr = {waddr[31:2], 2'b00};
    #1;
    chk("mem_req", 32'(bus.mem_req_o), 32'(ereq));
    chk("mem_addr", bus.mem_addr_o, waddr);
    chk("a_gnt", 32'(bus.a_gnt_o), 32'(egnt && !win));
    chk("b_gnt", 32'(bus.b_gnt_o), 32'(egnt && win));
    chk("busy", 32'(bus.busy_o), 32'(ereq || owners.size() != 0));
    chk("protocol_err", 32'(bus.protocol_err_o), 32'(m_prot));
    if (rstn) begin
      if (rv) begin
        if (owners.size() > 0) void'(owners.pop_front());
        else                   m_prot = 1'b1;
      end
      if (egnt) begin
        owners.push_back(win);
        last_id = win;
        held    = 1'b0;
      end else begin
        held    = ereq;
        held_id = win;
      end
    end
  endtask

  // Response monitor: every cycle with a routed or an expected response is scored.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.a_rvalid_o || bus.b_rvalid_o || exp_q.size() > 0) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rvalid", 32'({bus.a_rvalid_o, bus.b_rvalid_o}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("a_rvalid", 32'(bus.a_rvalid_o), 32'(e.id == 1'b0));
          chk("b_rvalid", 32'(bus.b_rvalid_o), 32'(e.id == 1'b1));
          chk("rdata", bus.rdata_o, e.data);
          chk("err", 32'(bus.err_o), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.a_req_i = 1'b0; bus.b_req_i = 1'b0;
    bus.a_addr_i = 32'h0; bus.b_addr_i = 32'h0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = 32'h0; bus.mem_err_i = 1'b0;

    // Reset state.
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // A alone, always granted, each fetch answered the following cycle.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, owners.size() > 0, 1'b1);
    step(1'b0, 1'b0, 1'b1, owners.size() > 0, 1'b1);

    // Both requesting every cycle: alternating grants, responses in issue order.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1, owners.size() > 0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, owners.size() > 0, 1'b1);

    // B stalls for three cycles while A joins; B's address must stay on the bus.
    b_fix_en = 1'b1;
    b_fix    = 32'hDEAD_BEEF;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    b_fix_en = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, owners.size() > 0, 1'b1);

    // Outstanding limit: responses withheld, then one freed slot.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, owners.size() > 0, 1'b1);

    // Random traffic; a stalled winner keeps requesting.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0,
           (owners.size() > 0) && ($urandom_range(0, 2) != 0), 1'b1);
    end

    // Drain, then a response with nothing outstanding.
    for (int i = 0; i < 20 && (owners.size() > 0 || held); i++) begin
      step(1'b0, 1'b0, 1'b1, owners.size() > 0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset with two fetches outstanding, then a normal A fetch.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    #3;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
